// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module   : mdu
// Brief    : Multi-cycle multiply/divide unit with HI/LO result registers.
//            Results are computed at start and committed when the busy
//            countdown expires.
// Revision : 1.0 - initial release
// ============================================================================
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic [3:0]  op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] result
);

  localparam int C_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int C_CNT_W      = (C_MAX_CYCLES < 2) ? 1 : $clog2(C_MAX_CYCLES + 1);

  localparam logic [C_CNT_W-1:0] C_MULT_N = C_CNT_W'(MULT_CYCLES);
  localparam logic [C_CNT_W-1:0] C_DIV_N  = C_CNT_W'(DIV_CYCLES);
  localparam logic [C_CNT_W-1:0] C_ONE    = C_CNT_W'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] C_OP_MULT  = 4'd1;
  localparam logic [3:0] C_OP_MULTU = 4'd2;
  localparam logic [3:0] C_OP_DIV   = 4'd3;
  localparam logic [3:0] C_OP_DIVU  = 4'd4;
  localparam logic [3:0] C_OP_MTHI  = 4'd5;
  localparam logic [3:0] C_OP_MTLO  = 4'd6;
  localparam logic [3:0] C_OP_MFHI  = 4'd7;
  localparam logic [3:0] C_OP_MFLO  = 4'd8;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [C_CNT_W-1:0] r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_p_hi;
  logic [31:0]        r_p_lo;
  logic               r_p_skip;

  logic               w_idle_start;
  logic               w_launch;
  logic               w_done;

  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [31:0]        w_abs_a;
  logic [31:0]        w_abs_b;
  logic [31:0]        w_den_s;
  logic [31:0]        w_den_u;
  logic [31:0]        w_mag_q;
  logic [31:0]        w_mag_r;
  logic [31:0]        w_quot_s;
  logic [31:0]        w_rem_s;
  logic [31:0]        w_quot_u;
  logic [31:0]        w_rem_u;

  logic [31:0]        w_p_hi;
  logic [31:0]        w_p_lo;
  logic               w_p_skip;
  logic [C_CNT_W-1:0] w_cnt_load;

  assign w_idle_start = (r_state == S_IDLE) && start;
  assign w_launch     = w_idle_start && (op >= C_OP_MULT) && (op <= C_OP_DIVU);
  assign w_done       = (r_state == S_RUN) && (r_cnt == C_ONE);

  // Multiplication: sign- or zero-extend to 64 bits, keep the low 64 of the product.
  assign w_prod_s = {{32{d1[31]}}, d1} * {{32{d2[31]}}, d2};
  assign w_prod_u = {32'd0, d1} * {32'd0, d2};

  // Signed division on magnitudes; 0x80000000 / -1 falls out naturally as 0x80000000.
  assign w_a_neg  = d1[31];
  assign w_b_neg  = d2[31];
  assign w_abs_a  = w_a_neg ? (32'd0 - d1) : d1;
  assign w_abs_b  = w_b_neg ? (32'd0 - d2) : d2;
  assign w_den_s  = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
  assign w_mag_q  = w_abs_a / w_den_s;
  assign w_mag_r  = w_abs_a % w_den_s;
  assign w_quot_s = (w_a_neg ^ w_b_neg) ? (32'd0 - w_mag_q) : w_mag_q;
  assign w_rem_s  = w_a_neg ? (32'd0 - w_mag_r) : w_mag_r;

  assign w_den_u  = (d2 == 32'd0) ? 32'd1 : d2;
  assign w_quot_u = d1 / w_den_u;
  assign w_rem_u  = d1 % w_den_u;

  always_comb begin
    w_p_hi     = 32'd0;
    w_p_lo     = 32'd0;
    w_p_skip   = 1'b0;
    w_cnt_load = C_MULT_N;
    case (op)
      C_OP_MULT: begin
        w_p_hi = w_prod_s[63:32];
        w_p_lo = w_prod_s[31:0];
      end
      C_OP_MULTU: begin
        w_p_hi = w_prod_u[63:32];
        w_p_lo = w_prod_u[31:0];
      end
      C_OP_DIV: begin
        w_p_hi     = w_rem_s;
        w_p_lo     = w_quot_s;
        w_p_skip   = (d2 == 32'd0);
        w_cnt_load = C_DIV_N;
      end
      C_OP_DIVU: begin
        w_p_hi     = w_rem_u;
        w_p_lo     = w_quot_u;
        w_p_skip   = (d2 == 32'd0);
        w_cnt_load = C_DIV_N;
      end
      default: begin
        w_p_hi = 32'd0;
      end
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_state_nxt = S_RUN;
      S_RUN:   if (w_done)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (r_state == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_p_hi   <= 32'd0;
      r_p_lo   <= 32'd0;
      r_p_skip <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - C_ONE;
      if (w_done && !r_p_skip) begin
        r_hi <= r_p_hi;
        r_lo <= r_p_lo;
      end
    end else if (w_launch) begin
      r_cnt    <= w_cnt_load;
      r_p_hi   <= w_p_hi;
      r_p_lo   <= w_p_lo;
      r_p_skip <= w_p_skip;
    end else if (w_idle_start && (op == C_OP_MTHI)) begin
      r_hi <= d1;
    end else if (w_idle_start && (op == C_OP_MTLO)) begin
      r_lo <= d1;
    end
  end

  always_comb begin
    result = 32'd0;
    if (op == C_OP_MFHI) begin
      result = r_hi;
    end else if (op == C_OP_MFLO) begin
      result = r_lo;
    end
  end

endmodule
`default_nettype wire
